// File: rtl/mips_cpu_regfile_dump.sv
// General-purpose register file for the MIPS CPU.
// N combinational read ports, one synchronous write port, optional
// hardwired-zero r0, optional write-to-read bypass, and a valid/ready
// dump engine that streams every register in index order for debug.
module mips_cpu_regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   read_index,
  output logic [NUM_READ*DATA_W-1:0]   read_data,
  input  logic [ADDR_W-1:0]            write_index,
  input  logic                         write_enable,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         dump_start,
  output logic                         dump_valid,
  input  logic                         dump_ready,
  output logic [ADDR_W-1:0]            dump_index,
  output logic [DATA_W-1:0]            dump_data,
  output logic                         dump_last,
  output logic                         dump_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  logic [DATA_W-1:0] regs [DEPTH];
  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic              write_allowed;

  // Read resolution shared by every read port and the dump engine:
  // reset forces zero, then the hardwired r0, then the same-cycle bypass,
  // then the stored word. All inputs are explicit arguments so callers in
  // always_comb stay sensitive to everything the result depends on.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              rst,
    input logic              we,
    input logic [ADDR_W-1:0] widx,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] result;
    result = stored;
    if (rst) begin
      result = '0;
    end else if (ZERO_REG != 0 && idx == '0) begin
      result = '0;
    end else if (BYPASS != 0 && we && widx == idx) begin
      result = wdata;
    end
    return result;
  endfunction

  assign write_allowed = write_enable && !(ZERO_REG != 0 && write_index == '0);

  // Register storage: cleared on reset, single write port otherwise.
  always_ff @(posedge clk) begin
    // NOTE: the whole array is cleared on reset because reads and dumps must
    // observe zeros right after reset; this keeps the storage in flops rather
    // than letting it map onto a reset-less RAM.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment for all clocked state so every
        // always_ff sees pre-edge values regardless of evaluation order.
        regs[i] <= '0;
      end
    end else if (write_allowed) begin
      regs[write_index] <= write_data;
    end
  end

  // Combinational read ports, each resolved independently.
  always_comb begin
    read_data = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      read_data[p*DATA_W +: DATA_W] = resolve(
        read_index[p*ADDR_W +: ADDR_W],
        regs[read_index[p*ADDR_W +: ADDR_W]],
        reset, write_enable, write_index, write_data);
    end
  end

  // Dump FSM state and beat pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Dump FSM next-state: start only from IDLE, advance on each transfer,
  // and return to IDLE after the beat at the highest index.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise
    // the missing branches would infer latches.
    state_next = state;
    ptr_next   = ptr;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          state_next = STREAM;
          ptr_next   = '0;
        end
      end
      STREAM: begin
        if (dump_ready) begin
          if (&ptr) begin
            state_next = IDLE;
            ptr_next   = '0;
          end else begin
            ptr_next = ptr + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Dump stream outputs; data tracks live contents so a stalled beat
  // reflects writes to its register.
  always_comb begin
    dump_busy  = (state == STREAM) && !reset;
    dump_valid = dump_busy;
    dump_last  = dump_busy && (&ptr);
    dump_index = ptr;
    dump_data  = resolve(ptr, regs[ptr], reset, write_enable, write_index, write_data);
  end

endmodule

// File: tb/tb_mips_cpu_regfile_dump.sv
// Self-checking bench for mips_cpu_regfile_dump: directed reads/writes are
// checked in place, dump beats are checked by a scoreboard monitor.
module tb_mips_cpu_regfile_dump;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NR     = 2;
  localparam int DEPTH  = 32;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NR*ADDR_W-1:0]  read_index;
  logic [NR*DATA_W-1:0]  read_data;
  logic [NR*DATA_W-1:0]  read_data_b;
  logic [ADDR_W-1:0]     write_index;
  logic                  write_enable;
  logic [DATA_W-1:0]     write_data;
  logic                  dump_start;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [ADDR_W-1:0]     dump_index;
  logic [DATA_W-1:0]     dump_data;
  logic                  dump_last;
  logic                  dump_busy;
  logic                  b_dump_start = 1'b0;
  logic                  b_dump_ready = 1'b0;
  logic                  b_dump_valid;
  logic [ADDR_W-1:0]     b_dump_index;
  logic [DATA_W-1:0]     b_dump_data;
  logic                  b_dump_last;
  logic                  b_dump_busy;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mips_cpu_regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NR),
                          .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .read_index(read_index), .read_data(read_data),
    .write_index(write_index), .write_enable(write_enable), .write_data(write_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_last(dump_last),
    .dump_busy(dump_busy)
  );

  mips_cpu_regfile_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_READ(NR),
                          .ZERO_REG(0), .BYPASS(1)) dut_nz (
    .clk(clk), .reset(reset),
    .read_index(read_index), .read_data(read_data_b),
    .write_index(write_index), .write_enable(write_enable), .write_data(write_data),
    .dump_start(b_dump_start), .dump_valid(b_dump_valid), .dump_ready(b_dump_ready),
    .dump_index(b_dump_index), .dump_data(b_dump_data), .dump_last(b_dump_last),
    .dump_busy(b_dump_busy)
  );

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted beat must match the next expectation.
  always @(negedge clk) begin
    if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dump_unexpected_beat: got index %0d, expected no beat", dump_index);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("dump_index", 64'(dump_index), 64'(e.idx));
        check("dump_data", 64'(dump_data), 64'(e.data));
        check("dump_last", 64'(dump_last), 64'(e.last));
      end
    end
  end

  function automatic logic [DATA_W-1:0] loaded(input int i);
    return DATA_W'(i * 3);
  endfunction

  task automatic push_beat(input int i, input logic [DATA_W-1:0] d);
    beat_t b;
    b.idx  = ADDR_W'(i);
    b.data = d;
    b.last = (i == DEPTH - 1);
    exp_q.push_back(b);
  endtask

  task automatic pulse_start();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
  endtask

  // Wait (bounded) for the final beat, then confirm the FSM went idle.
  task automatic wait_dump_done(input string name);
    bit found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dump_valid && dump_ready && dump_last) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no last beat, expected one within 200 cycles", name);
    end
    step();
    @(negedge clk);
    check({name, "_busy_after"}, 64'(dump_busy), 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic sweep_zero(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      read_index = {ADDR_W'(DEPTH - 1 - i), ADDR_W'(i)};
      @(negedge clk);
      check({name, "_p0"}, 64'(read_data[31:0]), 64'd0);
      check({name, "_p1"}, 64'(read_data[63:32]), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100us");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $finish;
  end

  initial begin
    bit written;
    bit hold_check;

    reset = 1'b1; read_index = '0; write_index = '0; write_enable = 1'b0;
    write_data = '0; dump_start = 1'b0; dump_ready = 1'b0;

    // 1: reads and dump outputs are zero while reset is asserted, then a sweep.
    step();
    read_index = {5'd31, 5'd5};
    @(negedge clk);
    check("reset_read_p0", 64'(read_data[31:0]), 64'd0);
    check("reset_read_p1", 64'(read_data[63:32]), 64'd0);
    check("reset_dump_valid", 64'(dump_valid), 64'd0);
    check("reset_dump_busy", 64'(dump_busy), 64'd0);
    check("reset_dump_last", 64'(dump_last), 64'd0);
    step();
    reset = 1'b0;
    sweep_zero("post_reset_sweep");

    // 2: bypass during the write cycle, storage on the next.
    step();
    write_enable = 1'b1; write_index = 5'd5; write_data = 32'hDEADBEEF;
    read_index = {5'd5, 5'd5};
    @(negedge clk);
    check("bypass_p0", 64'(read_data[31:0]), 64'hDEADBEEF);
    check("bypass_p1", 64'(read_data[63:32]), 64'hDEADBEEF);
    step();
    write_enable = 1'b0;
    @(negedge clk);
    check("stored_p0", 64'(read_data[31:0]), 64'hDEADBEEF);
    check("stored_p1", 64'(read_data[63:32]), 64'hDEADBEEF);

    // 3: r0 is hardwired with ZERO_REG=1, writable with ZERO_REG=0.
    step();
    write_enable = 1'b1; write_index = 5'd0; write_data = 32'h00001234;
    read_index = {5'd0, 5'd0};
    @(negedge clk);
    check("r0_zero_during_write", 64'(read_data[31:0]), 64'd0);
    check("r0_nz_bypass", 64'(read_data_b[31:0]), 64'h1234);
    step();
    write_enable = 1'b0;
    @(negedge clk);
    check("r0_zero_after_write", 64'(read_data[31:0]), 64'd0);
    check("r0_nz_stored", 64'(read_data_b[63:32]), 64'h1234);

    // Load r[i] = i*3.
    for (int i = 0; i < DEPTH; i++) begin
      step();
      write_enable = 1'b1; write_index = ADDR_W'(i); write_data = loaded(i);
    end
    step();
    write_enable = 1'b0;

    // 4: full-speed dump.
    for (int i = 0; i < DEPTH; i++) push_beat(i, loaded(i));
    dump_ready = 1'b1;
    pulse_start();
    wait_dump_done("dump_full_speed");

    // 5: ready toggles every 2 cycles, r7 written while beat 7 stalls,
    //    and a dump_start mid-stream must be ignored.
    for (int i = 0; i < DEPTH; i++) push_beat(i, (i == 7) ? 32'hCAFE0007 : loaded(i));
    dump_ready = 1'b0;
    pulse_start();
    written = 0;
    hold_check = 0;
    for (int c = 0; c < 300; c++) begin
      dump_ready = ((c + 3) >> 1) & 1;
      dump_start = (c == 3);
      write_enable = 1'b0;
      if (hold_check && dump_valid && !dump_ready) begin
        @(negedge clk);
        check("stall_hold_index", 64'(dump_index), 64'd7);
        check("stall_hold_data", 64'(dump_data), 64'hCAFE0007);
        hold_check = 0;
      end else if (!written && dump_valid && dump_index == 5'd7 && !dump_ready) begin
        write_enable = 1'b1; write_index = 5'd7; write_data = 32'hCAFE0007;
        written = 1;
        hold_check = 1;
        @(negedge clk);
        check("stall_write_index", 64'(dump_index), 64'd7);
        check("stall_write_data", 64'(dump_data), 64'hCAFE0007);
      end else begin
        hold_check = 0;
      end
      step();
      if (!dump_busy) break;
    end
    dump_ready = 1'b0; dump_start = 1'b0; write_enable = 1'b0;
    check("stall_write_happened", 64'(written), 64'd1);
    @(negedge clk);
    check("stall_dump_busy_after", 64'(dump_busy), 64'd0);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset during beat 10 aborts the dump and clears every register.
    for (int i = 0; i < 10; i++) push_beat(i, (i == 7) ? 32'hCAFE0007 : loaded(i));
    dump_ready = 1'b1;
    pulse_start();
    begin
      bit found = 0;
      for (int n = 0; n < 100; n++) begin
        if (dump_valid && dump_index == 5'd10) begin
          found = 1;
          break;
        end
        step();
      end
      if (!found) begin
        tests++;
        fails++;
        $display("FAIL abort_reach_beat10: got no beat 10, expected it within 100 cycles");
      end
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_valid_in_reset", 64'(dump_valid), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid_after", 64'(dump_valid), 64'd0);
    check("abort_busy_after", 64'(dump_busy), 64'd0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    sweep_zero("abort_sweep");
    read_index = {5'd7, 5'd7};
    @(negedge clk);
    check("abort_r7_nz_cleared", 64'(read_data_b[31:0]), 64'd0);
    step();
    for (int i = 0; i < DEPTH; i++) push_beat(i, 32'd0);
    pulse_start();
    wait_dump_done("dump_after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
